// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART blocks
package uart_pkg;

  // Default divisor: 50 MHz system clock to 115200 baud.
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // One-hot transmitter states.
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    PAR   = 5'b01000,
    STOP  = 5'b10000
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with input FIFO
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          Clock,
  input  logic                          reset_,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          Serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(DATA_W) + 1;

  generate
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_width
      $error("uart_tx_param: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_div
      $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  state_t              state;
  state_t              state_nx;
  logic [BCW-1:0]      baud_cnt;
  logic [BIW-1:0]      bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic                par_bit;
  logic                serial_nx;
  logic                rdy_en;
  logic                bit_done;
  logic                last_data;
  logic                last_stop;
  logic                pop;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rd_data;

  // rdy_en keeps in_ready low during reset and for the first cycle after it.
  assign in_ready  = rdy_en && !fifo_full;
  assign push      = in_valid && in_ready;
  assign tx_busy   = (state != IDLE) || !fifo_empty;
  assign bit_done  = (baud_cnt == BCW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_idx == BIW'(DATA_W - 1));
  assign last_stop = (bit_idx == BIW'(STOP_BITS - 1));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (reset_),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next state, FIFO pop and the next registered line level.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    serial_nx = Serial_out;
    unique case (state)
      IDLE: begin
        serial_nx = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nx  = START;
          serial_nx = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_nx  = DATA;
          serial_nx = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (last_data) begin
            if (PARITY != PARITY_NONE) begin
              state_nx  = PAR;
              serial_nx = par_bit;
            end else begin
              state_nx  = STOP;
              serial_nx = 1'b1;
            end
          end else begin
            serial_nx = shreg[0];
          end
        end
      end
      PAR: begin
        if (bit_done) begin
          state_nx  = STOP;
          serial_nx = 1'b1;
        end
      end
      STOP: begin
        if (bit_done && last_stop) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nx  = START;
            serial_nx = 1'b0;
          end else begin
            state_nx  = IDLE;
            serial_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx  = IDLE;
        serial_nx = 1'b1;
      end
    endcase
  end

  // State, line, baud counter, bit counter and shift register.
  always_ff @(posedge Clock or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      Serial_out <= 1'b1;
      rdy_en     <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
    end else begin
      state      <= state_nx;
      Serial_out <= serial_nx;
      rdy_en     <= 1'b1;
      if (pop) begin
        shreg    <= fifo_rd_data;
        par_bit  <= (PARITY == PARITY_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state == IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else begin
        baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
        if (bit_done) begin
          case (state)
            START: begin
              shreg   <= shreg >> 1;
              bit_idx <= '0;
            end
            DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= last_data ? '0 : bit_idx + 1'b1;
            end
            STOP:    bit_idx <= bit_idx + 1'b1;
            default: bit_idx <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It is the next generation of the fixed 8N1 transmitter. Adds configurable data width, parity mode, stop-bit count and an internal baud divisor. Parallel words enter through a valid/ready handshake into a small FIFO and are serialised LSB-first on Serial_out. Sits between the host data path and the FPGA TX pin; the single-word register and external tick of the old block are retired.

Parameters:
DATA_W, 8, data bits per frame (5..9)
CLKS_PER_BIT, 434, Clock cycles per bit (>=2); 434 = 50 MHz / 115200
PARITY, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)

Ports:
Clock  input  1  system clock, all logic on rising edge
reset_  input  1  asynchronous, active-low reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data valid this cycle
in_ready  output  1  FIFO can accept; transfer when in_valid && in_ready at a rising edge
Serial_out  output  1  registered UART line, idle high
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_ low, async): Serial_out=1, in_ready=0 while asserted, tx_busy=0, fifo_count=0. FIFO is emptied, FSM goes to IDLE, baud counter=0. Reset mid-frame aborts the frame; the line returns high immediately, with no partial stop bit.
- After release: in_ready = (fifo_count != FIFO_DEPTH). It does not look ahead, so a push and pop in the same cycle when full is not possible. When not full, a push and pop in the same cycle leaves the count unchanged.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every frame start. bit_done asserts when count == CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if FIFO non-empty, pop into shift reg and go to START. Serial_out=0 is registered at that edge.
  - START: on bit_done go to DATA; drive bit0.
  - DATA: on bit_done shift right. After DATA_W bits go to PAR (if PARITY!=0) else STOP.
  - PAR: drive the parity bit. Even: parity = XOR(data). Odd: parity = ~XOR(data). On bit_done go to STOP.
  - STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (Serial_out=0 the next cycle, no idle gap); else go to IDLE.
- Latency: a word accepted at edge E0 into an empty FIFO with FSM in IDLE is popped at E1. Serial_out falls at E1.
- Every bit is held exactly CLKS_PER_BIT cycles. Frame length = (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT.
- The parity value is computed from the popped word and stored at pop time.
- tx_busy = (state != IDLE) || (fifo_count != 0), registered-consistent with state.
- Invalid parameters (PARITY>2, STOP_BITS not in {1,2}) trigger an elaboration-time error, not silent fallback.

Decomposition:
- Package uart_pkg: FSM state encoding (one-hot localparams IDLE/START/DATA/PAR/STOP), PARITY_NONE/EVEN/ODD constants, CLKS_PER_BIT default.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) is reused later by the receiver.
- Baud counter and FSM stay inline.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; push 0x03 after reset -> Serial_out at E1 onward: 0,1,1,0,0,0,0,0,0,1, each 4 cycles; frame 40 cycles; tx_busy drops after the last stop cycle.
- PARITY=1 push 0x07 -> parity bit 1. PARITY=2 push 0x07 -> parity bit 0. Frame 44 cycles.
- FIFO_DEPTH=4, in_valid held high with words 0x10..0x15 -> words 0x10..0x14 accepted on E0..E4; in_ready low from E4. 0x15 is accepted only after 0x11 is popped.
- Back-to-back: two words queued, STOP_BITS=2 -> second start bit begins the cycle after the 8th stop-bit cycle of the first frame; no idle gap.
- reset_ pulsed low mid-DATA of 0xA5 -> Serial_out=1 asynchronously, fifo_count=0, in_ready=0 while low. After release, 1 idle cycle then in_ready=1, and no residual frame.
- DATA_W=5, CLKS_PER_BIT=2, push 0x1F (upper bits ignored) -> 0,1,1,1,1,1,1, each 2 cycles.
